// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter.
//   - Width encodings used on both the requester ports and the downstream bus.
//   - Arbiter FSM state type.
//   - Pending-request record latched per requester on dispatch.
// Pending fields are sized for the widest supported bus (32-bit address and
// data); narrower instances use the low bits.
package mem_arb_pkg;

   localparam logic [1:0] MEM_BYTE  = 2'd0;
   localparam logic [1:0] MEM_WORD  = 2'd1;
   localparam logic [1:0] MEM_DWORD = 2'd2;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [1:0]            width;
      logic [ARB_DATA_W-1:0] data;
      logic                  is_write;
   } pend_req_t;

   // Index following idx, wrapping at n.
   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   pending   : one bit per requester with a latched request
//   rr_ptr    : index with highest priority this round
//   grant     : one-hot winner (first pending index at or after rr_ptr)
//   grant_vld : at least one request is pending
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_vld
);

   always_comb begin
      int               idx;
      logic [PTR_W-1:0] sel;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // Modulo by subtraction keeps non-power-of-two NUM_REQ correct.
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PTR_W'(idx);
         if (!grant_vld && pending[sel]) begin
            grant[sel] = 1'b1;
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory bus between NUM_REQ requesters.
// Each requester gets a private single-cycle dispatch / busy port; requests
// are latched, granted round-robin and issued one at a time downstream.
//   clk_in, rst_in (async, active-low)
//   req_dispatch_read/write, req_addr, req_width, req_write_data : requester side in
//   req_busy, req_read_data                                       : requester side out
//   mem_dispatch_read/write, mem_addr, mem_width, mem_write_data  : bus side out
//   mem_read_data, mem_busy                                       : bus side in
// ADDR_W and DATA_W are supported up to 32.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_REQ-1:0]        req_dispatch_read,
   input  logic [NUM_REQ-1:0]        req_dispatch_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*2-1:0]      req_width,
   input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
   output logic [NUM_REQ-1:0]        req_busy,
   output logic [NUM_REQ*DATA_W-1:0] req_read_data,
   output logic                      mem_dispatch_read,
   output logic                      mem_dispatch_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [1:0]                mem_width,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic [DATA_W-1:0]         mem_read_data,
   input  logic                      mem_busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   arb_state_t         state;
   pend_req_t          pend [NUM_REQ];
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   win_idx;
   logic [CNT_W-1:0]   ack_cnt;
   logic [NUM_REQ-1:0] grant;
   logic               grant_vld;
   logic               done;

   // req_busy doubles as the pending-valid flag for each requester.
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .pending   (req_busy),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_vld (grant_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) win_idx = PTR_W'(i);
   end

   // A silent bus (no busy within ACK_TIMEOUT cycles) counts as complete.
   always_comb begin
      done = 1'b0;
      if (state == ST_WAIT_ACK && !mem_busy && ack_cnt == CNT_W'(ACK_TIMEOUT - 1))
         done = 1'b1;
      if (state == ST_WAIT_DONE && !mem_busy)
         done = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state              <= ST_IDLE;
         rr_ptr             <= '0;
         gnt_idx            <= '0;
         ack_cnt            <= '0;
         req_busy           <= '0;
         req_read_data      <= '0;
         mem_dispatch_read  <= 1'b0;
         mem_dispatch_write <= 1'b0;
         mem_addr           <= '0;
         mem_width          <= '0;
         mem_write_data     <= '0;
         for (int i = 0; i < NUM_REQ; i++) pend[i] <= '0;
      end else begin
         // Capture: only idle ports accept; read+write together is a write.
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((req_dispatch_read[i] || req_dispatch_write[i]) && !req_busy[i]) begin
               req_busy[i]      <= 1'b1;
               pend[i].addr     <= ARB_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
               pend[i].width    <= req_width[i*2 +: 2];
               pend[i].data     <= ARB_DATA_W'(req_write_data[i*DATA_W +: DATA_W]);
               pend[i].is_write <= req_dispatch_write[i];
            end
         end

         mem_dispatch_read  <= 1'b0;
         mem_dispatch_write <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_vld && !mem_busy) begin
                  gnt_idx            <= win_idx;
                  mem_addr           <= pend[win_idx].addr[ADDR_W-1:0];
                  mem_width          <= pend[win_idx].width;
                  mem_write_data     <= pend[win_idx].data[DATA_W-1:0];
                  mem_dispatch_write <= pend[win_idx].is_write;
                  mem_dispatch_read  <= !pend[win_idx].is_write;
                  state              <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ack_cnt <= '0;
               state   <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (mem_busy)  state   <= ST_WAIT_DONE;
               else if (done) state   <= ST_IDLE;
               else           ack_cnt <= ack_cnt + 1'b1;
            end
            ST_WAIT_DONE: begin
               if (done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Completion; the granted port is busy, so capture above cannot collide.
         if (done) begin
            if (!pend[gnt_idx].is_write)
               req_read_data[int'(gnt_idx)*DATA_W +: DATA_W] <= mem_read_data;
            req_busy[gnt_idx] <= 1'b0;
            rr_ptr            <= PTR_W'(next_idx(int'(gnt_idx), NUM_REQ));
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   logic        clk_in;
   logic        rst_in;
   logic [1:0]  req_dispatch_read;
   logic [1:0]  req_dispatch_write;
   logic [63:0] req_addr;
   logic [3:0]  req_width;
   logic [63:0] req_write_data;
   logic [1:0]  req_busy;
   logic [63:0] req_read_data;
   logic        mem_dispatch_read;
   logic        mem_dispatch_write;
   logic [31:0] mem_addr;
   logic [1:0]  mem_width;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_busy;

   int n_checks = 0;
   int n_errors = 0;

   // Bus model controls and log
   int          busy_len = 1;
   logic [31:0] rd_val   = '0;
   int          n_disp   = 0;
   int          n_log    = 0;
   logic [31:0] log_addr [64];
   logic [1:0]  log_width[64];
   logic [31:0] log_data [64];
   logic        log_wr   [64];

   mem_bus_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(4)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .req_dispatch_read  (req_dispatch_read),
      .req_dispatch_write (req_dispatch_write),
      .req_addr           (req_addr),
      .req_width          (req_width),
      .req_write_data     (req_write_data),
      .req_busy           (req_busy),
      .req_read_data      (req_read_data),
      .mem_dispatch_read  (mem_dispatch_read),
      .mem_dispatch_write (mem_dispatch_write),
      .mem_addr           (mem_addr),
      .mem_width          (mem_width),
      .mem_write_data     (mem_write_data),
      .mem_read_data      (mem_read_data),
      .mem_busy           (mem_busy)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Count every cycle a downstream dispatch is high.
   initial begin
      forever begin
         @(negedge clk_in);
         if (mem_dispatch_read || mem_dispatch_write) n_disp++;
      end
   end

   // Downstream bus: busy rises the cycle after dispatch and lasts busy_len cycles.
   initial begin
      mem_busy      = 1'b0;
      mem_read_data = '0;
      forever begin
         @(negedge clk_in);
         if (rst_in && (mem_dispatch_read || mem_dispatch_write)) begin
            log_addr[n_log]  = mem_addr;
            log_width[n_log] = mem_width;
            log_data[n_log]  = mem_write_data;
            log_wr[n_log]    = mem_dispatch_write;
            n_log++;
            mem_read_data = rd_val;
            if (busy_len > 0) begin
               @(posedge clk_in); #1;
               mem_busy = 1'b1;
               repeat (busy_len) @(posedge clk_in);
               #1;
               mem_busy = 1'b0;
            end
         end
      end
   end

   task automatic set_port(input int i, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] w, input logic [31:0] d);
      req_dispatch_read[i]     = rd;
      req_dispatch_write[i]    = wr;
      req_addr[i*32 +: 32]     = a;
      req_width[i*2 +: 2]      = w;
      req_write_data[i*32 +: 32] = d;
   endtask

   // Hold the staged dispatches for exactly one cycle.
   task automatic pulse();
      @(posedge clk_in); #1;
      req_dispatch_read  = '0;
      req_dispatch_write = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Cycles until req_busy[i] drops, bounded.
   task automatic wait_free(input int i, output int cyc);
      cyc = 0;
      while (req_busy[i] && cyc < 50) begin
         @(posedge clk_in); #1;
         cyc++;
      end
      if (req_busy[i]) check("busy_release_timeout", 64'(req_busy[i]), 64'd0);
   endtask

   initial begin
      int cyc;
      int d0;
      int l0;
      rst_in             = 1'b0;
      req_dispatch_read  = '0;
      req_dispatch_write = '0;
      req_addr           = '0;
      req_width          = '0;
      req_write_data     = '0;

      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_busy",  64'(req_busy), 64'd0);
      check("rst_disp",  64'({mem_dispatch_read, mem_dispatch_write}), 64'd0);
      check("rst_addr",  64'(mem_addr), 64'd0);
      check("rst_rdata", req_read_data, 64'd0);
      rst_in = 1'b1;
      idle(1);

      // Single read, 2-cycle downstream busy
      busy_len = 2; rd_val = 32'hDEADBEEF; d0 = n_disp; l0 = n_log;
      set_port(0, 1'b1, 1'b0, 32'h100, MEM_WORD, 32'h0);
      pulse();
      check("rd_busy_t1", 64'(req_busy[0]), 64'd1);
      wait_free(0, cyc);
      check("rd_latency", 64'(cyc), 64'd5);
      check("rd_ndisp",   64'(n_disp - d0), 64'd1);
      check("rd_addr",    64'(log_addr[l0]), 64'h100);
      check("rd_is_read", 64'(log_wr[l0]), 64'd0);
      check("rd_data",    64'(req_read_data[31:0]), 64'hDEADBEEF);
      idle(2);

      // Minimum latency on requester 1 with 1-cycle busy
      busy_len = 1; rd_val = 32'h11112222;
      set_port(1, 1'b1, 1'b0, 32'h180, MEM_WORD, 32'h0);
      pulse();
      wait_free(1, cyc);
      check("min_latency", 64'(cyc), 64'd4);
      check("min_data",    64'(req_read_data[63:32]), 64'h11112222);
      idle(2);

      // Byte write passthrough on requester 1
      busy_len = 1; rd_val = 32'hBAD0BAD0; d0 = n_disp; l0 = n_log;
      set_port(1, 1'b0, 1'b1, 32'h2003, MEM_BYTE, 32'h12);
      pulse();
      wait_free(1, cyc);
      check("wr_ndisp", 64'(n_disp - d0), 64'd1);
      check("wr_addr",  64'(log_addr[l0]), 64'h2003);
      check("wr_width", 64'(log_width[l0]), 64'(MEM_BYTE));
      check("wr_data",  64'(log_data[l0]), 64'h12);
      check("wr_is_wr", 64'(log_wr[l0]), 64'd1);
      check("wr_rdata_kept", 64'(req_read_data[63:32]), 64'h11112222);
      idle(2);

      // Simultaneous writes, twice: grant order 0 then 1 both rounds
      for (int r = 0; r < 2; r++) begin
         busy_len = 1; d0 = n_disp; l0 = n_log;
         set_port(0, 1'b0, 1'b1, 32'hA000 + 32'(r*256), MEM_DWORD, 32'h1111);
         set_port(1, 1'b0, 1'b1, 32'hB000 + 32'(r*256), MEM_DWORD, 32'h2222);
         pulse();
         wait_free(0, cyc);
         wait_free(1, cyc);
         check("pair_ndisp",  64'(n_disp - d0), 64'd2);
         check("pair_first",  64'(log_addr[l0]),   64'hA000 + 64'(r*256));
         check("pair_second", 64'(log_addr[l0+1]), 64'hB000 + 64'(r*256));
         check("pair_data1",  64'(log_data[l0+1]), 64'h2222);
         idle(2);
      end

      // Re-dispatch while busy is ignored
      busy_len = 3; rd_val = 32'h13579BDF; d0 = n_disp; l0 = n_log;
      set_port(0, 1'b1, 1'b0, 32'h300, MEM_WORD, 32'h0);
      pulse();
      idle(2);
      set_port(0, 1'b1, 1'b0, 32'h400, MEM_WORD, 32'h0);
      pulse();
      wait_free(0, cyc);
      idle(6);
      check("redisp_ndisp", 64'(n_disp - d0), 64'd1);
      check("redisp_addr",  64'(log_addr[l0]), 64'h300);
      check("redisp_data",  64'(req_read_data[31:0]), 64'h13579BDF);
      check("redisp_idle",  64'(req_busy), 64'd0);

      // Timeout: downstream never raises busy
      busy_len = 0; rd_val = 32'h5555AAAA;
      set_port(0, 1'b1, 1'b0, 32'h500, MEM_WORD, 32'h0);
      pulse();
      wait_free(0, cyc);
      check("tmo_latency", 64'(cyc), 64'd6);
      check("tmo_data",    64'(req_read_data[31:0]), 64'h5555AAAA);
      idle(2);

      // Reset during WAIT_DONE
      busy_len = 4; rd_val = 32'h77778888;
      set_port(1, 1'b1, 1'b0, 32'h600, MEM_WORD, 32'h0);
      pulse();
      idle(3);
      #2;
      rst_in = 1'b0;
      #1;
      check("mrst_busy",  64'(req_busy), 64'd0);
      check("mrst_addr",  64'(mem_addr), 64'd0);
      check("mrst_rdata", req_read_data, 64'd0);
      check("mrst_disp",  64'({mem_dispatch_read, mem_dispatch_write}), 64'd0);
      cyc = 0;
      while (mem_busy && cyc < 20) begin
         @(posedge clk_in); #1;
         cyc++;
      end
      check("mrst_bus_quiet", 64'(mem_busy), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle(1);
      busy_len = 1; rd_val = 32'hCAFEF00D; l0 = n_log;
      set_port(1, 1'b1, 1'b0, 32'h700, MEM_WORD, 32'h0);
      pulse();
      wait_free(1, cyc);
      check("post_latency", 64'(cyc), 64'd4);
      check("post_addr",    64'(log_addr[l0]), 64'h700);
      check("post_data",    64'(req_read_data[63:32]), 64'hCAFEF00D);
      check("post_data0",   64'(req_read_data[31:0]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one downstream memory bus between NUM_REQ requesters, e.g. the CPU data port (requester 0) and the video/DMA fetcher (requester 1).
- Each requester sees a private port with the single-cycle dispatch / busy protocol of the memory bus.
- The arbiter latches requests, grants round-robin, and issues one downstream transaction at a time.
- It returns read data and releases busy only to the granted requester.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
ACK_TIMEOUT, 4, cycles to wait for downstream busy to rise before treating the access as complete

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
req_dispatch_read  input  NUM_REQ  per-requester single-cycle read request
req_dispatch_write  input  NUM_REQ  per-requester single-cycle write request
req_addr  input  NUM_REQ*ADDR_W  per-requester address, sampled on dispatch
req_width  input  NUM_REQ*2  per-requester mem::BYTE/WORD/DWORD, sampled on dispatch
req_write_data  input  NUM_REQ*DATA_W  per-requester store data, sampled on dispatch
req_busy  output  NUM_REQ  per-requester busy
req_read_data  output  NUM_REQ*DATA_W  per-requester load result
mem_dispatch_read  output  1  downstream read pulse
mem_dispatch_write  output  1  downstream write pulse
mem_addr  output  ADDR_W  downstream address
mem_width  output  2  downstream width
mem_write_data  output  DATA_W  downstream store data
mem_read_data  input  DATA_W  downstream load data
mem_busy  input  1  downstream busy

Behaviour:
Reset (rst_in low, asynchronous):
- All outputs 0; pending regs cleared; state IDLE; rr pointer 0; timeout counter 0.
- Any in-flight downstream access is abandoned.

Request capture:
- A dispatch in cycle T while req_busy[i]=0 latches addr/width/data/is_write into pending[i] at the edge ending T.
- req_busy[i]=1 from T+1.
- Dispatch while req_busy[i]=1 is ignored; no state change.
- Read and write asserted together: treated as a write.

FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if any pending and mem_busy=0, grant the first pending index at or after rr_ptr (wrapping modulo NUM_REQ). Drive mem_addr/width/write_data from the winner, assert the matching mem_dispatch_* for exactly one cycle, then go to ISSUE. If mem_busy=1, stay in IDLE.
- ISSUE: deassert dispatch; go to WAIT_ACK; load the timeout counter.
- WAIT_ACK: mem_busy=1 goes to WAIT_DONE. Counter reaching ACK_TIMEOUT with no busy counts as complete: take the completion action, then go to IDLE.
- WAIT_DONE: on mem_busy=0, take the completion action, then go to IDLE.
- Completion action: req_read_data[g] <= mem_read_data (reads only), req_busy[g] <= 0, clear pending[g], rr_ptr <= (g+1) mod NUM_REQ.

Outputs and timing:
- mem_addr/width/write_data hold stable from issue until completion.
- req_read_data[i] holds until the next completed read for requester i; writes leave it unchanged.
- Minimum latency: dispatch in T; mem dispatch high in T+2; with a 1-cycle downstream busy (T+3), req_busy falls and data is valid at T+5.
- A requester dispatching in the same cycle its completion is registered is not accepted; busy is still 1 in that cycle.
- At most one downstream transaction is outstanding. The grant is never preempted.
- Fairness: with all requesters continuously pending, grants rotate 0,1,...,NUM_REQ-1,0.

Decomposition:
- Package mem_arb_pkg holds the FSM enum (arb_state_t), the pending-request struct (addr, width, data, is_write), and the width encodings reused from mem.
- One sub-module: rr_arbiter. It is combinational, takes a pending vector and rr_ptr, and outputs a one-hot grant plus a valid flag.

Test Plan:
- Single read: requester 0 reads 0x100; downstream busy 2 cycles, returns 0xDEADBEEF -> one mem_dispatch_read with mem_addr=0x100; req_busy[0] high T+1..T+5; req_read_data[0]=0xDEADBEEF.
- Simultaneous: requesters 0 and 1 both write in the same cycle, rr_ptr=0 -> req 0 issued first, req 1 issued after req 0 completes; rr_ptr ends at 0. Repeat -> next same-cycle pair grants 0 then 1 again.
- Width/data passthrough: req 1 writes 0x12 with BYTE to 0x2003 -> mem_width=BYTE, mem_write_data=0x12, mem_dispatch_write exactly 1 cycle, req_read_data[1] unchanged.
- Ignored re-dispatch: second read from req 0 while req_busy[0]=1 -> no extra downstream dispatch; first result delivered.
- Timeout: downstream never raises busy -> completion after ACK_TIMEOUT=4 cycles in WAIT_ACK; req_busy clears.
- Reset mid-transaction: rst_in low during WAIT_DONE -> all outputs 0 immediately; after release, a fresh read from req 1 completes normally.
